// File: rtl/fft_engine_scheduler.sv
// fft_engine_scheduler: round-robin owner of the shared FFT engine for the header and body
// convolution wrappers, with a per-job watchdog and a CPU command/status pair.
module fft_engine_scheduler #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hdr_req,
  output logic       hdr_gnt,
  output logic       hdr_done,
  input  logic       body_req,
  output logic       body_gnt,
  output logic       body_done,
  output logic       fft_sel,
  output logic       fft_start,
  input  logic       fft_busy,
  input  logic       fft_done,
  input  logic [1:0] cpu_cmd,
  output logic [1:0] status
);
  typedef enum logic [2:0] {IDLE, START, RUN, DONE, ERR} state_t;
  localparam logic [TO_W-1:0] WD_MAX = TO_W'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic sel_q, sel_d, last_q, last_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic abort, win, job;
  assign abort = cpu_cmd[1];
  // On a tie the requester that was not served last wins; last_q=1 means body.
  assign win = (hdr_req && body_req) ? ~last_q : body_req;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = (state_q == DONE) ? sel_q : last_q;
    wd_d    = (state_q == START) ? '0 : (state_q == RUN) ? wd_q + 1'b1 : wd_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:
          if (cpu_cmd[0] && !fft_busy && (hdr_req || body_req)) begin
            state_d = START;
            sel_d   = win;
          end
        START: state_d = RUN;
        RUN:   state_d = fft_done ? DONE : (wd_q == WD_MAX) ? ERR : RUN;
        DONE:  state_d = IDLE;
        ERR:   state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    job       = (state_q == START) || (state_q == RUN);
    hdr_gnt   = job && !sel_q;
    body_gnt  = job && sel_q;
    hdr_done  = (state_q == DONE) && !sel_q;
    body_done = (state_q == DONE) && sel_q;
    fft_sel   = sel_q;
    fft_start = (state_q == START);
    status    = {state_q == ERR, job || (state_q == DONE)};
  end
endmodule

// File: tb/tb_fft_engine_scheduler.sv
// tb_fft_engine_scheduler: vector table, directed corner sequences and a randomized run
// against a job-level reference model of the engine scheduler.
module tb_fft_engine_scheduler;
  localparam int T = 16;
  logic clk = 0, reset_n = 0, hdr_req = 0, body_req = 0, fft_busy = 0, fft_done = 0;
  logic [1:0] cpu_cmd = 2'b00;
  logic hdr_gnt, hdr_done, body_gnt, body_done, fft_sel, fft_start;
  logic [1:0] status;
  int checks = 0, errors = 0;

  fft_engine_scheduler #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .hdr_req(hdr_req), .hdr_gnt(hdr_gnt), .hdr_done(hdr_done),
    .body_req(body_req), .body_gnt(body_gnt), .body_done(body_done),
    .fft_sel(fft_sel), .fft_start(fft_start), .fft_busy(fft_busy), .fft_done(fft_done),
    .cpu_cmd(cpu_cmd), .status(status)
  );

  always #5 clk = ~clk;

  // Output vector order: hdr_gnt body_gnt hdr_done body_done fft_sel fft_start status[1:0]
  function automatic logic [7:0] outs();
    return {hdr_gnt, body_gnt, hdr_done, body_done, fft_sel, fft_start, status};
  endfunction

  task automatic chk(input string nm, input logic [7:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, outs(), exp);
    end
  endtask

  task automatic drive(input logic r, h, b, bz, d, input logic [1:0] c);
    reset_n = r; hdr_req = h; body_req = b; fft_busy = bz; fft_done = d; cpu_cmd = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Job-level reference: a job is granted, started, then runs until the engine reports
  // completion, the watchdog budget of T run cycles is spent, or the CPU aborts.
  int  m_job;
  int  m_cnt;
  bit  m_dn, m_own, m_err, m_last;

  task automatic model_step(input logic r, h, b, bz, d, input logic [1:0] c);
    if (!r) begin
      m_job = 0; m_dn = 0; m_own = 0; m_err = 0; m_last = 1; m_cnt = 0;
    end else if (c[1]) begin
      m_job = 0; m_dn = 0; m_err = 0;
    end else if (m_err) begin
      m_err = 1;
    end else if (m_dn) begin
      m_dn = 0;
    end else if (m_job == 1) begin
      m_job = 2; m_cnt = 0;
    end else if (m_job == 2) begin
      if (d) begin
        m_job = 0; m_dn = 1; m_last = m_own;
      end else if (m_cnt == T - 1) begin
        m_job = 0; m_err = 1;
      end else begin
        m_cnt++;
      end
    end else if (c[0] && !bz && (h || b)) begin
      m_own = (h && b) ? !m_last : b;
      m_job = 1;
    end
  endtask

  function automatic logic [7:0] m_exp();
    return {m_job != 0 && !m_own, m_job != 0 && m_own, m_dn && !m_own, m_dn && m_own,
            m_own, m_job == 1, m_err, m_job != 0 || m_dn};
  endfunction

  typedef struct {
    logic r, h, b, bz, d;
    logic [1:0] c;
    logic [7:0] e;
  } vec_t;
  vec_t tbl[22];

  initial begin
    logic hq, bq, r, d, bz;
    logic [1:0] c;
    logic o;
    logic [2:0] order;
    tbl[0]  = '{0, 0, 0, 0, 0, 2'b00, 8'b00000000};
    tbl[1]  = '{1, 1, 0, 0, 0, 2'b01, 8'b10000101};
    tbl[2]  = '{1, 1, 0, 0, 0, 2'b01, 8'b10000001};
    tbl[3]  = '{1, 1, 0, 0, 1, 2'b01, 8'b00100001};
    tbl[4]  = '{1, 0, 1, 0, 0, 2'b01, 8'b00000000};
    tbl[5]  = '{1, 0, 1, 0, 0, 2'b01, 8'b01001101};
    tbl[6]  = '{1, 0, 1, 0, 0, 2'b01, 8'b01001001};
    tbl[7]  = '{1, 0, 1, 0, 1, 2'b11, 8'b00001000};
    tbl[8]  = '{1, 0, 1, 0, 0, 2'b11, 8'b00001000};
    tbl[9]  = '{1, 1, 1, 0, 0, 2'b01, 8'b01001101};
    tbl[10] = '{1, 1, 1, 0, 1, 2'b01, 8'b01001001};
    tbl[11] = '{1, 1, 1, 0, 1, 2'b01, 8'b00011001};
    tbl[12] = '{1, 1, 1, 0, 0, 2'b01, 8'b00001000};
    tbl[13] = '{1, 1, 1, 0, 0, 2'b01, 8'b10000101};
    tbl[14] = '{1, 1, 1, 0, 0, 2'b00, 8'b10000001};
    tbl[15] = '{1, 1, 1, 0, 1, 2'b00, 8'b00100001};
    tbl[16] = '{1, 1, 1, 0, 0, 2'b00, 8'b00000000};
    tbl[17] = '{1, 1, 1, 0, 0, 2'b00, 8'b00000000};
    tbl[18] = '{1, 1, 1, 1, 0, 2'b01, 8'b00000000};
    tbl[19] = '{1, 1, 1, 0, 0, 2'b01, 8'b01001101};
    tbl[20] = '{1, 1, 1, 1, 0, 2'b01, 8'b01001001};
    tbl[21] = '{0, 1, 1, 0, 0, 2'b01, 8'b00000000};
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].h, tbl[i].b, tbl[i].bz, tbl[i].d, tbl[i].c);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].e);
    end

    // Header job with fft_done 10 cycles after fft_start
    drive(0, 0, 0, 0, 0, 2'b00); tick(); chk("t1_reset", 8'b00000000);
    drive(1, 1, 0, 0, 0, 2'b01); tick(); chk("t1_start", 8'b10000101);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 1, 0, 1, 0, 2'b01); tick(); chk($sformatf("t1_run%0d", i), 8'b10000001);
    end
    drive(1, 1, 0, 0, 1, 2'b01); tick(); chk("t1_done", 8'b00100001);
    drive(1, 0, 0, 0, 0, 2'b01); tick(); chk("t1_idle", 8'b00000000);

    // Both requesters held for three jobs: header, body, header
    drive(0, 0, 0, 0, 0, 2'b00); tick();
    order = 3'b010;
    for (int j = 0; j < 3; j++) begin
      o = order[2 - j];
      drive(1, 1, 1, 0, 0, 2'b01); tick(); chk($sformatf("t2_start%0d", j), {~o, o, 2'b00, o, 1'b1, 2'b01});
      drive(1, 1, 1, 1, 0, 2'b01); tick(); chk($sformatf("t2_run%0d", j), {~o, o, 2'b00, o, 1'b0, 2'b01});
      drive(1, 1, 1, 0, 1, 2'b01); tick(); chk($sformatf("t2_done%0d", j), {2'b00, ~o, o, o, 1'b0, 2'b01});
      drive(1, 1, 1, 0, 0, 2'b01); tick(); chk($sformatf("t2_idle%0d", j), {4'b0000, o, 3'b000});
    end

    // Watchdog expiry, error hold and abort clear
    drive(0, 0, 0, 0, 0, 2'b00); tick();
    drive(1, 1, 0, 0, 0, 2'b01); tick(); chk("t3_start", 8'b10000101);
    for (int i = 0; i < T; i++) begin
      tick(); chk($sformatf("t3_run%0d", i), 8'b10000001);
    end
    tick(); chk("t3_err", 8'b00000010);
    drive(1, 0, 0, 0, 1, 2'b01); tick(); chk("t3_err_hold", 8'b00000010);
    drive(1, 0, 0, 0, 0, 2'b11); tick(); chk("t3_abort", 8'b00000000);

    // fft_done on the cycle the watchdog would expire
    drive(0, 0, 0, 0, 0, 2'b00); tick();
    drive(1, 1, 0, 0, 0, 2'b01); tick(); chk("t4_start", 8'b10000101);
    for (int i = 0; i < T; i++) begin
      tick(); chk($sformatf("t4_run%0d", i), 8'b10000001);
    end
    drive(1, 1, 0, 0, 1, 2'b01); tick(); chk("t4_done", 8'b00100001);
    drive(1, 0, 0, 0, 0, 2'b01); tick(); chk("t4_idle", 8'b00000000);

    // Randomized traffic against the reference model
    hq = 0; bq = 0;
    drive(0, 0, 0, 0, 0, 2'b00); model_step(0, 0, 0, 0, 0, 2'b00); tick();
    chk("rand_reset", m_exp());
    for (int i = 0; i < 4000; i++) begin
      if (!hq) hq = ($urandom_range(3) == 0);
      else if (m_dn && !m_own && $urandom_range(1) == 1) hq = 0;
      if (!bq) bq = ($urandom_range(3) == 0);
      else if (m_dn && m_own && $urandom_range(1) == 1) bq = 0;
      r  = ($urandom_range(299) != 0);
      d  = ($urandom_range(5) == 0);
      bz = ($urandom_range(3) == 0);
      c  = {$urandom_range(39) == 0, $urandom_range(7) != 0};
      drive(r, hq, bq, bz, d, c);
      model_step(r, hq, bq, bz, d, c);
      tick();
      chk($sformatf("rand%0d", i), m_exp());
      checks++;
      if (hdr_gnt && body_gnt) begin
        errors++;
        $display("FAIL rand_excl%0d: got both grants %b%b expected at most one", i, hdr_gnt, body_gnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
